// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_e;

    // Force an externally supplied target onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return pc & ~ADDR_W'(32'h3);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with predictor steering and redirect flush.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               bp_hit,
    input  logic               bp_taken,
    input  logic [ADDR_W-1:0]  bp_pred_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_4
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic               imem_req_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks every other event.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = redirect ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect || if_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                // A redirect here only retargets PC; the stale response still retires the slot.
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: PC steering, request tag and decode-side capture.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        if (redirect) begin
            pc_d = align_pc(redirect_pc);
        end

        unique case (state_q)
            ST_REQ: begin
                if (imem_gnt && !redirect) begin
                    req_pc_d = pc_q;
                    pc_d     = (bp_hit && bp_taken) ? align_pc(bp_pred_pc) : pc_q + PC_STEP;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid && !redirect) begin
                    if_valid_d = 1'b1;
                    if_instr_d = imem_rdata;
                    if_pc_d    = req_pc_q;
                end
            end
            ST_HOLD: begin
                if (redirect || if_ready) begin
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                if_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; the request strobe is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            imem_req_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            imem_req_q <= (state_d == ST_REQ);
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_pc_4   = if_pc_q + PC_STEP;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios followed by randomized traffic.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        bp_hit;
    logic        bp_taken;
    logic [31:0] bp_pred_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_4;

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .bp_hit      (bp_hit),
        .bp_taken    (bp_taken),
        .bp_pred_pc  (bp_pred_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_4     (if_pc_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;

    // Transaction-level reference: what is fetched next, what is in flight, what decode holds.
    bit          m_started, m_inflight, m_killed, m_holding;
    logic [31:0] m_pc, m_inflight_pc, m_hold_instr, m_hold_pc;
    int          mem_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] al(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic model_reset();
        m_started  = 1'b0;
        m_inflight = 1'b0;
        m_killed   = 1'b0;
        m_holding  = 1'b0;
        m_pc       = RST_PC;
        mem_cnt    = 0;
        sb_q.delete();
    endtask

    task automatic clear_inputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        bp_hit = 1'b0; bp_taken = 1'b0; bp_pred_pc = '0;
        redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    endtask

    // One cycle: drive at negedge, check visible outputs against the model, then advance the model.
    task automatic step(input bit g, input bit rv, input logic [31:0] rd,
                        input bit hit, input bit tk, input logic [31:0] pred,
                        input bit rdr, input logic [31:0] rpc, input bit rdy);
        bit exp_req;
        bit granted;
        @(negedge clk);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        bp_hit = hit; bp_taken = tk; bp_pred_pc = pred;
        redirect = rdr; redirect_pc = rpc; if_ready = rdy;
        #1;
        exp_req = m_started && !m_inflight && !m_holding;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_holding));
        if (m_holding) begin
            chk("hold_instr", if_instr, m_hold_instr);
            chk("hold_pc", if_pc, m_hold_pc);
            chk("hold_pc_4", if_pc_4, m_hold_pc + 32'd4);
        end
        granted = 1'b0;
        if (!m_started) begin
            m_started = 1'b1;
            if (rdr) m_pc = al(rpc);
        end else if (m_holding) begin
            if (rdr) begin
                m_holding = 1'b0;
                m_pc = al(rpc);
            end else if (rdy) begin
                sb_q.push_back({m_hold_instr, m_hold_pc});
                m_holding = 1'b0;
            end
        end else if (m_inflight) begin
            if (rdr) m_pc = al(rpc);
            if (rv) begin
                m_inflight = 1'b0;
                if (!(m_killed || rdr)) begin
                    m_holding    = 1'b1;
                    m_hold_instr = rd;
                    m_hold_pc    = m_inflight_pc;
                end
            end else if (rdr) begin
                m_killed = 1'b1;
            end
        end else begin
            if (g) begin
                granted       = 1'b1;
                m_inflight    = 1'b1;
                m_killed      = rdr;
                m_inflight_pc = m_pc;
                if (rdr) m_pc = al(rpc);
                else if (hit && tk) m_pc = al(pred);
                else m_pc = m_pc + 32'd4;
            end else if (rdr) begin
                m_pc = al(rpc);
            end
        end
        if (granted) mem_cnt = int'($urandom_range(0, 3));
        else if (m_inflight && !rv && mem_cnt > 0) mem_cnt--;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic rand_step();
        bit          g, rv, rdr;
        logic [31:0] rpc;
        g   = ($urandom_range(0, 9) < 6);
        rv  = m_inflight ? (mem_cnt == 0) : ($urandom_range(0, 9) == 0);
        rdr = ($urandom_range(0, 99) < 8);
        if (m_inflight && m_killed && rv) rdr = 1'b0;
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        step(g, rv, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             rdr, rpc, ($urandom_range(0, 9) < 6));
    endtask

    // Monitor: every decode handshake retires the oldest expected instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && if_valid && if_ready && !redirect) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h instr %h, expected no delivery", if_pc, if_instr);
                end else begin
                    e = sb_q.pop_front();
                    n_pops++;
                    chk("sb_instr", if_instr, e.instr);
                    chk("sb_pc", if_pc, e.pc);
                    chk("sb_pc_4", if_pc_4, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        rst = 1'b0;

        // First fetch after reset with single-cycle memory.
        idle(1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        chk("first_valid", 32'(if_valid), 32'd1);
        chk("first_instr", if_instr, 32'h0000_0013);
        chk("first_pc", if_pc, 32'd0);
        chk("first_pc_4", if_pc_4, 32'd4);
        idle(1'b1);

        // Predicted-taken target with misaligned low bits.
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0010, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h0000_0103, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        chk("bp_target", imem_addr, 32'h0000_0100);
        step(1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1'b1);
        @(posedge clk); #1;
        chk("bp_req", 32'(imem_req), 32'd1);
        chk("bp_req_addr", imem_addr, 32'h0000_0100);

        // Redirect while waiting; the late response is discarded.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0200, 1'b0);
        idle(1'b0);
        step(1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        @(posedge clk); #1;
        chk("drop_valid", 32'(if_valid), 32'd0);
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'h0000_0200);

        // Decode back-pressure holds the instruction stable.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (5) idle(1'b0);
        @(posedge clk); #1;
        chk("hold5_instr", if_instr, 32'hDEAD_BEEF);
        chk("hold5_pc", if_pc, 32'h0000_0200);
        chk("hold5_req", 32'(imem_req), 32'd0);
        idle(1'b1);
        @(posedge clk); #1;
        chk("hold_release_req", 32'(imem_req), 32'd1);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        chk("wrap_addr", imem_addr, 32'd0);
        step(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_pc_4", if_pc_4, 32'd0);
        idle(1'b1);

        // Asynchronous reset while a request is outstanding.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_imem_req", 32'(imem_req), 32'd0);
        chk("arst_if_valid", 32'(if_valid), 32'd0);
        chk("arst_if_instr", if_instr, 32'd0);
        chk("arst_if_pc", if_pc, 32'd0);
        chk("arst_imem_addr", imem_addr, RST_PC);
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("arst_release_addr", imem_addr, RST_PC);
        step(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // Randomized traffic.
        repeat (3000) rand_step();
        idle(1'b0);
        #3;

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("sb_enough_deliveries", 32'(n_pops >= 50), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
